obstacle_motion_ctrl: RTL

//  Producer of obstacle_x for the obstacle sprite bitgen. Once per video frame it steps the

---
 rtl/obstacle_motion_ctrl_pkg.sv | 27 ++
 rtl/obstacle_motion_ctrl_lfsr8.sv | 34 +++
 rtl/obstacle_motion_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/obstacle_motion_ctrl_pkg.sv
// Shared constants, state encoding and LFSR step function for the obstacle motion controller.
// Positions are in pixels and gaps are in video frames.
package obstacle_motion_ctrl_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int TICK_LINE     = 480;
    localparam int MIN_GAP       = 30;
    localparam int GAP_BITS      = 6;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Wide enough for MIN_GAP + 2^GAP_BITS - 1.
    localparam int GAP_W = $clog2(MIN_GAP + (1 << GAP_BITS));

    typedef enum logic {
        ST_WAIT_GAP = 1'b0,
        ST_MOVE     = 1'b1
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_motion_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR that advances one position on each cycle where step is high.
// It holds otherwise; only reset reloads the seed.
module lfsr8
    import obstacle_motion_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       pix_clk,
    input  logic       reset,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] q_d;
    logic [7:0] q_q;

    always_comb begin
        q_d = q_q;
        if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge pix_clk) begin
        if (reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/obstacle_motion_ctrl.sv
// Steps the obstacle left once per frame during vertical blanking.
// After it exits the left edge it parks off-screen right for a pseudo-random number of frames.
module obstacle_motion_ctrl
    import obstacle_motion_ctrl_pkg::*;
(
    input  logic             pix_clk,
    input  logic             reset,
    input  logic [9:0]       hcount,
    input  logic [9:0]       vcount,
    input  logic             enable,
    input  logic             restart,
    input  logic [3:0]       speed,
    output logic [9:0]       obstacle_x,
    output logic             obstacle_active,
    output logic             passed_pulse,
    output logic [7:0]       passed_count,
    output state_t           dbg_state,
    output logic [GAP_W-1:0] dbg_gap_cnt,
    output logic [7:0]       dbg_lfsr
);

    localparam logic [9:0]       PARK_X  = 10'(SCREEN_WIDTH);
    localparam logic [9:0]       TICK_V  = 10'(TICK_LINE);
    localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(MIN_GAP);

    logic             tick_d, tick_q;
    state_t           state_d, state_q;
    logic [9:0]       x_d, x_q;
    logic [GAP_W-1:0] gap_d, gap_q;
    logic             active_d, active_q;
    logic             pulse_d, pulse_q;
    logic [7:0]       count_d, count_q;

    logic             qual_tick;
    logic             lfsr_step;
    logic [7:0]       lfsr_q;

    assign tick_d    = (hcount == 10'd0) && (vcount == TICK_V);
    assign qual_tick = tick_q && enable;
    // A restart swallows a coincident tick entirely, so the LFSR does not advance on it.
    assign lfsr_step = qual_tick && !restart;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .pix_clk (pix_clk),
        .reset   (reset),
        .step    (lfsr_step),
        .q       (lfsr_q)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        gap_d    = gap_q;
        active_d = active_q;
        pulse_d  = 1'b0;
        count_d  = count_q;

        if (restart) begin
            state_d  = ST_WAIT_GAP;
            x_d      = PARK_X;
            gap_d    = GAP_MIN;
            active_d = 1'b0;
            count_d  = 8'd0;
        end else if (qual_tick) begin
            case (state_q)
                ST_WAIT_GAP: begin
                    x_d = PARK_X;
                    if (gap_q == '0) begin
                        state_d  = ST_MOVE;
                        active_d = 1'b1;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                ST_MOVE: begin
                    // Exit check uses <= so the subtraction below never goes below 1.
                    if ((speed != 4'd0) && (x_q <= {6'd0, speed})) begin
                        state_d  = ST_WAIT_GAP;
                        x_d      = PARK_X;
                        gap_d    = GAP_MIN + GAP_W'(lfsr_q[GAP_BITS-1:0]);
                        active_d = 1'b0;
                        pulse_d  = 1'b1;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end else begin
                        x_d = x_q - {6'd0, speed};
                    end
                end
                default: begin
                    state_d = ST_WAIT_GAP;
                end
            endcase
        end
    end

    always_ff @(posedge pix_clk) begin
        if (reset) begin
            tick_q   <= 1'b0;
            state_q  <= ST_WAIT_GAP;
            x_q      <= PARK_X;
            gap_q    <= GAP_MIN;
            active_q <= 1'b0;
            pulse_q  <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            tick_q   <= tick_d;
            state_q  <= state_d;
            x_q      <= x_d;
            gap_q    <= gap_d;
            active_q <= active_d;
            pulse_q  <= pulse_d;
            count_q  <= count_d;
        end
    end

    assign obstacle_x      = x_q;
    assign obstacle_active = active_q;
    assign passed_pulse    = pulse_q;
    assign passed_count    = count_q;
    assign dbg_state       = state_q;
    assign dbg_gap_cnt     = gap_q;
    assign dbg_lfsr        = lfsr_q;

endmodule
